// File: rtl/axi_write_master.sv
// AXI4 write master: drains 32-bit words from a FWFT FIFO into INCR bursts of at most
// 256 B that never straddle a 4 KB boundary, with one burst outstanding at a time.
module axi_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_dst_addr,
    input  logic [31:0]                       i_total_len,
    output logic                              o_write_done,
    output logic                              o_write_error,
    output logic                              o_busy,
    input  logic                              i_fifo_empty,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_w_data,
    output logic                              o_fifo_pop,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [2:0]                        o_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_AW   = 3'd2;
    localparam logic [2:0] S_W    = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; a raised valid (with its payload) is held until then.

    logic [2:0]                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                   rem_q, rem_d;
    logic [8:0]                    bb_q, bb_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]                    awlen_q, awlen_d;
    logic [7:0]                    beat_q, beat_d;
    logic                          err_q, err_d;

    logic [12:0] bnd;
    logic [31:0] cap;
    logic [8:0]  bb_calc;
    logic [7:0]  awlen_calc;
    logic        w_fire;

    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awvalid = (state_q == S_AW);
    assign m_axi_wvalid  = (state_q == S_W) && !i_fifo_empty;
    assign m_axi_wdata   = (state_q == S_W) ? i_w_data : '0;
    assign m_axi_wlast   = (state_q == S_W) && (beat_q == 8'd0);
    assign m_axi_bready  = (state_q == S_B);
    assign w_fire        = m_axi_wvalid && m_axi_wready;
    assign o_fifo_pop    = w_fire;
    assign o_write_done  = (state_q == S_DONE);
    assign o_write_error = err_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_state       = state_q;

    // Burst bytes: the smallest of what is left, 256 B, and the distance to the next 4 KB page.
    always_comb begin
        bnd = 13'h1000 - {1'b0, addr_q[11:0]};
        cap = (rem_q < 32'd256) ? rem_q : 32'd256;
        if ({19'd0, bnd} < cap) begin
            bb_calc = bnd[8:0];
        end else begin
            bb_calc = cap[8:0];
        end
        awlen_calc = {1'b0, bb_calc[8:2]} - 8'd1;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        bb_d     = bb_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        beat_d   = beat_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_dst_addr & ~C_M_AXI_ADDR_WIDTH'(3);
                    rem_d   = i_total_len & ~32'd3;
                    err_d   = 1'b0;
                    state_d = ((i_total_len & ~32'd3) == 32'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                bb_d     = bb_calc;
                awaddr_d = addr_q;
                awlen_d  = awlen_calc;
                beat_d   = awlen_calc;
                state_d  = S_AW;
            end
            S_AW: begin
                if (m_axi_awready) state_d = S_W;
            end
            S_W: begin
                if (w_fire) begin
                    if (beat_q == 8'd0) begin
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q - 8'd1;
                    end
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) err_d = 1'b1;
                    addr_d  = addr_q + C_M_AXI_ADDR_WIDTH'(bb_q);
                    rem_d   = rem_q - {23'd0, bb_q};
                    state_d = (rem_q == {23'd0, bb_q}) ? S_DONE : S_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            bb_q     <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            bb_q     <= bb_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

endmodule
